// File: rtl/systolic_array_sequencer.sv
// Phase sequencer for one GEMM tile: IDLE -> WARMUP -> STEADY -> DRAIN -> IDLE.
// Optional tile cycle counter output enabled with `define SEQ_PERF_COUNTER_EN.
module systolic_array_sequencer #(
  parameter int NUM_ROW              = 8,
  parameter int NUM_COL              = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int DRAIN_EXTRA          = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_end_addr,
  input  logic [NUM_COL-1:0]              i_sa_datapath_valid_down,
  output logic [3:0]                      o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done
`ifdef SEQ_PERF_COUNTER_EN
  ,
  output logic [31:0]                     o_tile_cycles
`endif
);

  localparam int AW        = LOG2_SRAM_BANK_DEPTH;
  localparam int CW        = AW + 1;
  localparam int DRAIN_LEN = NUM_ROW + NUM_COL + DRAIN_EXTRA;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);

  generate
    if (DRAIN_LEN >= (1 << AW)) begin : g_drain_len_check
      $error("drain length must be below the SRAM bank depth");
    end
  endgenerate

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WARMUP = 4'd1,
    ST_STEADY = 4'd2,
    ST_DRAIN  = 4'd3
  } state_t;

  // Wrap-around windows (end <= start) count as empty.
  function automatic logic [AW-1:0] win_len(input logic [AW-1:0] s, input logic [AW-1:0] e);
    return (e > s) ? (e - s) : '0;
  endfunction

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] top_len, left_len;
  logic [AW-1:0] top_len_in, left_len_in;
  logic [CW-1:0] top_last, left_last;
  logic          done_nxt;
  logic          accept;

  assign top_len_in  = win_len(i_top_sram_rd_start_addr, i_top_sram_rd_end_addr);
  assign left_len_in = win_len(i_left_sram_rd_start_addr, i_left_sram_rd_end_addr);
  assign top_last    = {1'b0, top_len} - CW'(1);
  assign left_last   = {1'b0, left_len} - CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          accept  = 1'b1;
          cnt_nxt = '0;
          if (top_len_in != '0)       state_nxt = ST_WARMUP;
          else if (left_len_in != '0) state_nxt = ST_STEADY;
          else                        state_nxt = ST_DRAIN;
        end
      end
      ST_WARMUP: begin
        if (cnt == top_last) begin
          cnt_nxt   = '0;
          state_nxt = (left_len != '0) ? ST_STEADY : ST_DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_STEADY: begin
        if (cnt == left_last) begin
          cnt_nxt   = '0;
          state_nxt = ST_DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        // Counter parks at the minimum length while the array is still emitting.
        if (cnt >= DRAIN_LAST && i_sa_datapath_valid_down == '0) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (cnt < DRAIN_LAST) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
    if (i_abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= ST_IDLE;
      cnt                       <= '0;
      o_busy                    <= 1'b0;
      o_done                    <= 1'b0;
      top_len                   <= '0;
      left_len                  <= '0;
      o_top_sram_rd_start_addr  <= '0;
      o_top_sram_rd_end_addr    <= '0;
      o_left_sram_rd_start_addr <= '0;
      o_left_sram_rd_end_addr   <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_busy <= (state_nxt != ST_IDLE);
      o_done <= done_nxt;
      if (accept) begin
        top_len                   <= top_len_in;
        left_len                  <= left_len_in;
        o_top_sram_rd_start_addr  <= i_top_sram_rd_start_addr;
        o_top_sram_rd_end_addr    <= i_top_sram_rd_end_addr;
        o_left_sram_rd_start_addr <= i_left_sram_rd_start_addr;
        o_left_sram_rd_end_addr   <= i_left_sram_rd_end_addr;
      end
    end
  end

  assign o_ctrl_state = state;

`ifdef SEQ_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tile_cycles <= '0;
    end else if (accept) begin
      o_tile_cycles <= '0;
    end else if (o_busy && o_tile_cycles != '1) begin
      o_tile_cycles <= o_tile_cycles + 32'd1;
    end
  end
`endif

endmodule
